// File: rtl/regfile_arbiter.sv
// regfile_arbiter: arbitrates core (A) and debug (B) accesses to one register file.
// Optional REGARB_ROUND_ROBIN_EN alternates simultaneous grants; default is fixed A priority.
package regfile_arbiter_pkg;
  typedef enum logic [1:0] {
    REG_0 = 2'd0,
    REG_1 = 2'd1,
    REG_2 = 2'd2,
    REG_3 = 2'd3
  } register_sel_e;

  typedef enum logic [0:0] {
    REG_NOP = 1'b0,
    INWRITE = 1'b1
  } registers_op_e;
endpackage

module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_a,
  input  logic                      req_b,
  input  logic                      we_a,
  input  logic                      we_b,
  input  register_sel_e             sel_a,
  input  register_sel_e             sel_b,
  input  logic [DATA_BUS_WIDTH-1:0] wdata_a,
  input  logic [DATA_BUS_WIDTH-1:0] wdata_b,
  output logic                      gnt_a,
  output logic                      gnt_b,
  output logic                      done_a,
  output logic                      done_b,
  output logic [DATA_BUS_WIDTH-1:0] rdata,
  output registers_op_e             op_o,
  output register_sel_e             sel1_o,
  output register_sel_e             sel2_o,
  output logic [DATA_BUS_WIDTH-1:0] wdata_o,
  input  logic [DATA_BUS_WIDTH-1:0] reg_1_in
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e                    state_r;
  state_e                    state_nxt_s;
  logic                      req_any_s;
  logic                      win_b_s;

  logic                      gnt_a_r,   gnt_a_nxt_s;
  logic                      gnt_b_r,   gnt_b_nxt_s;
  logic                      done_a_r,  done_a_nxt_s;
  logic                      done_b_r,  done_b_nxt_s;
  logic [DATA_BUS_WIDTH-1:0] rdata_r,   rdata_nxt_s;
  registers_op_e             op_r,      op_nxt_s;
  register_sel_e             sel_r,     sel_nxt_s;
  logic [DATA_BUS_WIDTH-1:0] wdata_r,   wdata_nxt_s;

  assign req_any_s = req_a | req_b;

`ifdef REGARB_ROUND_ROBIN_EN
  logic last_b_r;

  // Remembers which port won the most recent access (B after reset).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_b_r <= 1'b1;
    end else if ((state_r == ST_IDLE) && req_any_s) begin
      last_b_r <= win_b_s;
    end else begin
      last_b_r <= last_b_r;
    end
  end

  // Simultaneous requests go to the port that lost last time.
  always_comb begin
    if (req_a && req_b) begin
      win_b_s = ~last_b_r;
    end else begin
      win_b_s = req_b;
    end
  end
`else
  // Fixed priority: A wins whenever it requests.
  always_comb begin
    win_b_s = req_b & ~req_a;
  end
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_any_s) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_nxt_s = ST_DONE;
      ST_DONE:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Output next values; ACCESS controls are loaded straight from the winner's inputs.
  always_comb begin
    gnt_a_nxt_s  = 1'b0;
    gnt_b_nxt_s  = 1'b0;
    done_a_nxt_s = 1'b0;
    done_b_nxt_s = 1'b0;
    rdata_nxt_s  = rdata_r;
    op_nxt_s     = REG_NOP;
    sel_nxt_s    = REG_0;
    wdata_nxt_s  = {DATA_BUS_WIDTH{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (req_any_s) begin
          gnt_a_nxt_s = ~win_b_s;
          gnt_b_nxt_s = win_b_s;
          if (win_b_s) begin
            op_nxt_s    = we_b ? INWRITE : REG_NOP;
            sel_nxt_s   = sel_b;
            wdata_nxt_s = wdata_b;
          end else begin
            op_nxt_s    = we_a ? INWRITE : REG_NOP;
            sel_nxt_s   = sel_a;
            wdata_nxt_s = wdata_a;
          end
        end else begin
          gnt_a_nxt_s = 1'b0;
          gnt_b_nxt_s = 1'b0;
        end
      end
      ST_ACCESS: begin
        // The register file wrote on the falling edge, so reg_1_in already shows new data.
        gnt_a_nxt_s  = gnt_a_r;
        gnt_b_nxt_s  = gnt_b_r;
        done_a_nxt_s = gnt_a_r;
        done_b_nxt_s = gnt_b_r;
        rdata_nxt_s  = reg_1_in;
      end
      ST_DONE: begin
        gnt_a_nxt_s = 1'b0;
        gnt_b_nxt_s = 1'b0;
      end
      default: begin
        gnt_a_nxt_s = 1'b0;
        gnt_b_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers; the async reset also pulls op_o out of INWRITE immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt_a_r  <= 1'b0;
      gnt_b_r  <= 1'b0;
      done_a_r <= 1'b0;
      done_b_r <= 1'b0;
      rdata_r  <= {DATA_BUS_WIDTH{1'b0}};
      op_r     <= REG_NOP;
      sel_r    <= REG_0;
      wdata_r  <= {DATA_BUS_WIDTH{1'b0}};
    end else begin
      gnt_a_r  <= gnt_a_nxt_s;
      gnt_b_r  <= gnt_b_nxt_s;
      done_a_r <= done_a_nxt_s;
      done_b_r <= done_b_nxt_s;
      rdata_r  <= rdata_nxt_s;
      op_r     <= op_nxt_s;
      sel_r    <= sel_nxt_s;
      wdata_r  <= wdata_nxt_s;
    end
  end

  assign gnt_a   = gnt_a_r;
  assign gnt_b   = gnt_b_r;
  assign done_a  = done_a_r;
  assign done_b  = done_b_r;
  assign rdata   = rdata_r;
  assign op_o    = op_r;
  assign sel1_o  = sel_r;
  assign sel2_o  = sel_r;
  assign wdata_o = wdata_r;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: directed table, corner sequences, random accesses.
// Expectations come from a transaction-level model of the arbitration and register contents.
module tb_regfile_arbiter;
  import regfile_arbiter_pkg::*;

  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           req_a, req_b, we_a, we_b;
  register_sel_e  sel_a, sel_b;
  logic [W-1:0]   wdata_a, wdata_b;
  logic           gnt_a, gnt_b, done_a, done_b;
  logic [W-1:0]   rdata, wdata_o, reg_1_in;
  registers_op_e  op_o;
  register_sel_e  sel1_o, sel2_o;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  regfile_arbiter #(.DATA_BUS_WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .sel_a(sel_a), .sel_b(sel_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .rdata(rdata), .op_o(op_o), .sel1_o(sel1_o), .sel2_o(sel2_o),
    .wdata_o(wdata_o), .reg_1_in(reg_1_in)
  );

  // Register file attached to the arbiter: writes on the falling edge.
  logic [W-1:0] rf [4] = '{default: 8'h00};
  always @(negedge clock) begin
    if (op_o == INWRITE) rf[sel2_o] <= wdata_o;
  end
  assign reg_1_in = rf[sel1_o];

  // Reference model state.
  logic [W-1:0] mdl_rf [4] = '{default: 8'h00};
  logic [W-1:0] mdl_rdata  = 8'h00;
  logic         mdl_last_b = 1'b1;

  typedef struct {
    logic          ra, rb, wa, wb;
    register_sel_e sa, sb;
    logic [W-1:0]  da, db;
    int            exp_win;   // 0 none, 1 A, 2 B
    logic [W-1:0]  exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_winner(input logic ra, input logic rb);
    if (ra && rb) begin
`ifdef REGARB_ROUND_ROBIN_EN
      return mdl_last_b ? 1 : 2;
`else
      return 1;
`endif
    end else if (ra) return 1;
    else if (rb) return 2;
    else return 0;
  endfunction

  function automatic vec_t with_expect(input vec_t v);
    vec_t r = v;
    r.exp_win = model_winner(v.ra, v.rb);
    if (r.exp_win == 1)      r.exp_rdata = v.wa ? v.da : mdl_rf[v.sa];
    else if (r.exp_win == 2) r.exp_rdata = v.wb ? v.db : mdl_rf[v.sb];
    else                     r.exp_rdata = mdl_rdata;
    return r;
  endfunction

  task automatic scramble_inputs(input bit rnd);
    if (rnd) begin
      req_a = 1'($urandom); req_b = 1'($urandom);
      we_a = 1'($urandom); we_b = 1'($urandom);
      sel_a = register_sel_e'($urandom_range(0, 3));
      sel_b = register_sel_e'($urandom_range(0, 3));
      wdata_a = W'($urandom); wdata_b = W'($urandom);
    end else begin
      req_a = 1'b0; req_b = 1'b0;
    end
  endtask

  // Starts one vector just after an edge in IDLE and returns just after the edge back into IDLE.
  task automatic apply(input vec_t v, input bit rnd);
    logic a, b, we;
    register_sel_e s;
    logic [W-1:0] d;
    a = (v.exp_win == 1); b = (v.exp_win == 2);
    we = b ? v.wb : v.wa; s = b ? v.sb : v.sa; d = b ? v.db : v.da;
    req_a = v.ra; req_b = v.rb; we_a = v.wa; we_b = v.wb;
    sel_a = v.sa; sel_b = v.sb; wdata_a = v.da; wdata_b = v.db;
    @(posedge clock); #1;
    if (v.exp_win != 0) scramble_inputs(rnd);
    @(negedge clock);
    check("access_gnt_a", gnt_a, a);
    check("access_gnt_b", gnt_b, b);
    check("access_done", {done_a, done_b}, 2'b00);
    if (v.exp_win != 0) begin
      check("access_op", op_o, we ? INWRITE : REG_NOP);
      check("access_sel1", sel1_o, s);
      check("access_sel2", sel2_o, s);
      check("access_wdata", wdata_o, d);
    end else begin
      check("idle_op", op_o, REG_NOP);
      check("idle_sel", {sel1_o, sel2_o}, 4'h0);
      check("idle_wdata", wdata_o, 8'h00);
    end
    @(posedge clock); #1;
    if (v.exp_win != 0) scramble_inputs(rnd);
    @(negedge clock);
    check("done_a", done_a, a);
    check("done_b", done_b, b);
    check("done_gnt", {gnt_a, gnt_b}, {a, b});
    check("rdata", rdata, v.exp_rdata);
    check("done_op", op_o, REG_NOP);
    check("done_wdata", wdata_o, 8'h00);
    if (v.exp_win != 0) begin
      if (we) mdl_rf[s] = d;
      mdl_last_b = b;
    end
    mdl_rdata = v.exp_rdata;
    @(posedge clock); #1;
    req_a = 1'b0; req_b = 1'b0;
  endtask

  // Grants must be mutually exclusive on every cycle.
  always @(negedge clock) begin
    if (reset) check("gnt_mutex", {31'd0, gnt_a & gnt_b}, 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [9];
    vec_t v;
    //             ra    rb    wa    wb    sa     sb     da     db     win rdata
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, REG_2, REG_0, 8'h5A, 8'h00, 1, 8'h5A};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, REG_2, REG_0, 8'h00, 8'h00, 1, 8'h5A};
`ifdef REGARB_ROUND_ROBIN_EN
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, REG_0, REG_1, 8'h11, 8'h22, 2, 8'h22};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, REG_0, REG_1, 8'h33, 8'h44, 1, 8'h33};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, REG_0, REG_1, 8'h55, 8'h66, 2, 8'h66};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, REG_0, REG_1, 8'h00, 8'h00, 2, 8'h66};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, REG_3, REG_3, 8'hEE, 8'hEE, 0, 8'h66};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, REG_0, REG_0, 8'h00, 8'h00, 1, 8'h33};
`else
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, REG_0, REG_1, 8'h11, 8'h22, 1, 8'h11};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, REG_0, REG_1, 8'h33, 8'h44, 1, 8'h33};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, REG_0, REG_1, 8'h55, 8'h66, 1, 8'h55};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, REG_0, REG_1, 8'h00, 8'h00, 2, 8'h00};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, REG_3, REG_3, 8'hEE, 8'hEE, 0, 8'h00};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, REG_0, REG_0, 8'h00, 8'h00, 1, 8'h55};
`endif
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, REG_0, REG_3, 8'h00, 8'hC3, 2, 8'hC3};

    reset = 1'b0;
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    sel_a = REG_0; sel_b = REG_0; wdata_a = 8'h00; wdata_b = 8'h00;
    repeat (2) @(negedge clock);
    check("rst_gnt_done", {gnt_a, gnt_b, done_a, done_b}, 4'h0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_op", op_o, REG_NOP);
    check("rst_sel_wdata", {sel1_o, sel2_o, wdata_o}, 12'h000);
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 9; i++) apply(tbl[i], 1'b1);

    // Early drop: req_a seen for one edge only, write FF to reg 1, then read it back.
    v = '{1'b1, 1'b0, 1'b1, 1'b0, REG_1, REG_0, 8'hFF, 8'h00, 0, 8'h00};
    apply(with_expect(v), 1'b0);
    v = '{1'b1, 1'b0, 1'b0, 1'b0, REG_1, REG_0, 8'h00, 8'h00, 0, 8'h00};
    apply(with_expect(v), 1'b0);
    check("early_drop_reg1", mdl_rf[1], 8'hFF);

    // Reset during ACCESS, before the falling edge where the write would land.
    req_a = 1'b1; we_a = 1'b1; sel_a = REG_3; wdata_a = 8'h3C;
    @(posedge clock); #2;
    reset = 1'b0; #1;
    check("midrst_op", op_o, REG_NOP);
    check("midrst_gnt_done", {gnt_a, gnt_b, done_a, done_b}, 4'h0);
    check("midrst_rdata", rdata, 8'h00);
    check("midrst_sel_wdata", {sel1_o, sel2_o, wdata_o}, 12'h000);
    req_a = 1'b0;
    @(negedge clock); #1;
    reset = 1'b1;
    mdl_rdata = 8'h00; mdl_last_b = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("midrst_no_done", {done_a, done_b}, 2'b00);
    end
    @(posedge clock); #1;
    v = '{1'b1, 1'b0, 1'b0, 1'b0, REG_3, REG_0, 8'h00, 8'h00, 0, 8'h00};
    v = with_expect(v);
    check("midrst_model_reg3", v.exp_rdata, 8'hC3);
    apply(v, 1'b1);

    // Random accesses checked against the model.
    for (int i = 0; i < 60; i++) begin
      v.ra = 1'($urandom); v.rb = 1'($urandom);
      v.wa = 1'($urandom); v.wb = 1'($urandom);
      v.sa = register_sel_e'($urandom_range(0, 3));
      v.sb = register_sel_e'($urandom_range(0, 3));
      v.da = W'($urandom); v.db = W'($urandom);
      apply(with_expect(v), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
